// File: rtl/spike_count_decoder.sv
// Spike-count decoder: accumulates per-neuron spike counts over T_STEPS valid beats,
// then resolves the winning neuron with a one-neuron-per-cycle argmax scan.
module spike_count_decoder #(
    parameter  int N_OUT   = 10,
    parameter  int T_STEPS = 16,
    localparam int CNT_W   = $clog2(T_STEPS + 1),
    localparam int IDX_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_OUT-1:0] spike_i,
    input  logic             valid_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [IDX_W-1:0] class_o,
    output logic [CNT_W-1:0] max_count_o,
    output logic             tie_o
);

    localparam int SCAN_W = $clog2(N_OUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCAN, S_DONE} state_t;

    state_t             r_state, w_next_state;
    logic [CNT_W-1:0]   r_cnt [N_OUT];
    logic [CNT_W-1:0]   r_step;
    logic [SCAN_W-1:0]  r_scan_idx;
    logic [CNT_W-1:0]   r_cmp_cnt;
    logic [IDX_W-1:0]   r_cmp_idx;
    logic               r_cmp_vld;
    logic [IDX_W-1:0]   r_best_idx;
    logic [CNT_W-1:0]   r_best_cnt;
    logic               r_best_tie;
    logic [IDX_W-1:0]   r_class;
    logic [CNT_W-1:0]   r_max;
    logic               r_tie;

    logic               w_start_ok, w_last_beat, w_scan_last;
    logic [CNT_W-1:0]   w_rd_cnt;
    logic [IDX_W-1:0]   w_best_idx;
    logic [CNT_W-1:0]   w_best_cnt;
    logic               w_best_tie;

    assign w_start_ok  = start_i && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last_beat = (r_state == S_ACCUM) && valid_i && (r_step == CNT_W'(T_STEPS - 1));
    assign w_scan_last = (r_state == S_SCAN) && r_cmp_vld && (r_cmp_idx == IDX_W'(N_OUT - 1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_rd_cnt = '0;
        for (int i = 0; i < N_OUT; i++)
            if (r_scan_idx == SCAN_W'(i)) w_rd_cnt = r_cnt[i];
    end

    // Strict greater-than keeps the lowest index on ties; equality past index 0 flags a tie.
    always_comb begin
        w_best_idx = r_best_idx;
        w_best_cnt = r_best_cnt;
        w_best_tie = r_best_tie;
        if (r_cmp_vld) begin
            if (r_cmp_cnt > r_best_cnt) begin
                w_best_idx = r_cmp_idx;
                w_best_cnt = r_cmp_cnt;
                w_best_tie = 1'b0;
            end else if (r_cmp_cnt == r_best_cnt && r_cmp_idx != '0) begin
                w_best_tie = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next_state = S_ACCUM;
            S_ACCUM: if (w_last_beat) w_next_state = S_SCAN;
            S_SCAN:  if (w_scan_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = w_start_ok ? S_ACCUM : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (r_state == S_ACCUM) || (r_state == S_SCAN);
        done_o = (r_state == S_DONE);
    end

    // NOTE: the counter array is a handful of flops that must read zero after an abort, so it is reset like any register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < N_OUT; i++) r_cnt[i] <= '0;
            r_step     <= '0;
            r_scan_idx <= '0;
            r_cmp_cnt  <= '0;
            r_cmp_idx  <= '0;
            r_cmp_vld  <= 1'b0;
            r_best_idx <= '0;
            r_best_cnt <= '0;
            r_best_tie <= 1'b0;
            r_class    <= '0;
            r_max      <= '0;
            r_tie      <= 1'b0;
        end else begin
            if (w_start_ok) begin
                for (int i = 0; i < N_OUT; i++) r_cnt[i] <= '0;
                r_step     <= '0;
                r_scan_idx <= '0;
                r_cmp_vld  <= 1'b0;
                r_best_idx <= '0;
                r_best_cnt <= '0;
                r_best_tie <= 1'b0;
                r_class    <= '0;
                r_max      <= '0;
                r_tie      <= 1'b0;
            end
            if (r_state == S_ACCUM && valid_i) begin
                for (int i = 0; i < N_OUT; i++) r_cnt[i] <= r_cnt[i] + CNT_W'(spike_i[i]);
                r_step <= r_step + 1'b1;
            end
            // Two-stage scan: register the selected count, compare it on the following edge.
            if (r_state == S_SCAN) begin
                if (r_scan_idx < SCAN_W'(N_OUT)) begin
                    r_cmp_cnt  <= w_rd_cnt;
                    r_cmp_idx  <= IDX_W'(r_scan_idx);
                    r_cmp_vld  <= 1'b1;
                    r_scan_idx <= r_scan_idx + 1'b1;
                end else begin
                    r_cmp_vld  <= 1'b0;
                end
                r_best_idx <= w_best_idx;
                r_best_cnt <= w_best_cnt;
                r_best_tie <= w_best_tie;
            end
            if (w_scan_last) begin
                r_class <= w_best_idx;
                r_max   <= w_best_cnt;
                r_tie   <= w_best_tie;
            end
        end
    end

    assign class_o     = r_class;
    assign max_count_o = r_max;
    assign tie_o       = r_tie;

endmodule

// File: tb/tb_spike_count_decoder.sv
// Self-checking bench for spike_count_decoder: a window model pushes expected results
// into a scoreboard queue, popped and compared when done_o pulses.
module tb_spike_count_decoder;

    localparam int N_OUT   = 10;
    localparam int T_STEPS = 16;
    localparam int CNT_W   = $clog2(T_STEPS + 1);
    localparam int IDX_W   = $clog2(N_OUT);
    localparam int LAT     = N_OUT + 1;

    typedef struct {
        logic [IDX_W-1:0] cls;
        logic [CNT_W-1:0] cnt;
        logic             tie;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [N_OUT-1:0] spike_i;
    logic             valid_i;
    logic             start_i;
    logic             busy_o;
    logic             done_o;
    logic [IDX_W-1:0] class_o;
    logic [CNT_W-1:0] max_count_o;
    logic             tie_o;

    logic [N_OUT-1:0] beat_vec [T_STEPS];
    exp_t             sb [$];
    int               n_checks = 0;
    int               n_fail   = 0;

    spike_count_decoder #(.N_OUT(N_OUT), .T_STEPS(T_STEPS)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .spike_i     (spike_i),
        .valid_i     (valid_i),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .class_o     (class_o),
        .max_count_o (max_count_o),
        .tie_o       (tie_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected result: maximum count, lowest index holding it, tie if more than one holds it.
    task automatic push_expected();
        int   cnt [N_OUT];
        int   mx;
        int   holders;
        exp_t e;
        mx = 0;
        holders = 0;
        for (int i = 0; i < N_OUT; i++) begin
            cnt[i] = 0;
            for (int b = 0; b < T_STEPS; b++) cnt[i] += int'(beat_vec[b][i]);
            if (cnt[i] > mx) mx = cnt[i];
        end
        e.cls = '0;
        for (int i = N_OUT - 1; i >= 0; i--)
            if (cnt[i] == mx) begin
                e.cls = IDX_W'(i);
                holders++;
            end
        e.cnt = CNT_W'(mx);
        e.tie = (holders > 1);
        sb.push_back(e);
    endtask

    // Start a window and feed beat_vec; gap_lo/gap_hi invalid all-ones cycles precede beats 0-7 / 8-15.
    task automatic drive_run(input int gap_lo, input int gap_hi, input int start_beat);
        push_expected();
        @(negedge clk_i);
        start_i = 1'b1;
        valid_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        n_checks++;
        if ({busy_o, done_o, class_o, max_count_o, tie_o} !== {1'b1, 1'b0, {IDX_W{1'b0}}, {CNT_W{1'b0}}, 1'b0}) begin
            n_fail++;
            $display("FAIL start_clear: busy/done/class/max/tie = %b/%b/%0d/%0d/%b, required 1/0/0/0/0",
                     busy_o, done_o, class_o, max_count_o, tie_o);
        end
        for (int b = 0; b < T_STEPS; b++) begin
            for (int g = 0; g < ((b < 8) ? gap_lo : gap_hi); g++) begin
                valid_i = 1'b0;
                spike_i = '1;
                @(negedge clk_i);
            end
            valid_i = 1'b1;
            spike_i = beat_vec[b];
            start_i = (b == start_beat);
            @(negedge clk_i);
        end
        start_i = 1'b0;
    endtask

    // Called at the negedge right after the edge that sampled the final beat.
    task automatic wait_result(input string tag);
        int   k;
        exp_t e;
        valid_i = 1'b0;
        spike_i = '0;
        k = 0;
        for (int c = 1; c <= 40 && k == 0; c++) begin
            @(negedge clk_i);
            if (done_o === 1'b1) k = c;
        end
        n_checks++;
        if (k == 0) begin
            n_fail++;
            $display("FAIL %s_timeout: done_o not seen within 40 cycles, required after %0d", tag, LAT);
            return;
        end
        if (k != LAT) begin
            n_fail++;
            $display("FAIL %s_latency: done_o after %0d edges, required %0d", tag, k, LAT);
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_scoreboard: done_o with no expected result queued, required none", tag);
        end else begin
            e = sb.pop_front();
            if (class_o !== e.cls) begin
                n_fail++;
                $display("FAIL %s_class: got %0d, required %0d", tag, class_o, e.cls);
            end
            n_checks++;
            if (max_count_o !== e.cnt) begin
                n_fail++;
                $display("FAIL %s_max: got %0d, required %0d", tag, max_count_o, e.cnt);
            end
            n_checks++;
            if (tie_o !== e.tie) begin
                n_fail++;
                $display("FAIL %s_tie: got %b, required %b", tag, tie_o, e.tie);
            end
        end
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy_at_done: got %b, required 0", tag, busy_o);
        end
        @(negedge clk_i);
        n_checks++;
        if (done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_width: done_o still %b one cycle later, required 0", tag, done_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            spike_i = N_OUT'($urandom);
            valid_i = 1'($urandom);
            start_i = 1'($urandom);
            @(negedge clk_i);
            n_checks++;
            if ({busy_o, done_o, class_o, max_count_o, tie_o} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: busy/done/class/max/tie = %b/%b/%0d/%0d/%b, required all 0",
                         busy_o, done_o, class_o, max_count_o, tie_o);
            end
        end
        start_i = 1'b0;
        valid_i = 1'b0;
        spike_i = '0;
        rst_i   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            n_checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle: done/busy = %b/%b, required 0/0", done_o, busy_o);
            end
        end
    endtask

    task automatic test_single_winner();
        for (int b = 0; b < T_STEPS; b++) beat_vec[b] = 10'b0000001000;
        drive_run(0, 0, -1);
        wait_result("single");
    endtask

    task automatic test_tie();
        for (int b = 0; b < T_STEPS; b++) begin
            beat_vec[b] = '0;
            beat_vec[b][2] = (b < 5);
            beat_vec[b][7] = (b >= 5 && b < 10);
            beat_vec[b][4] = (b < 3);
        end
        drive_run(0, 0, -1);
        wait_result("tie");
    endtask

    task automatic test_gaps();
        for (int b = 0; b < T_STEPS; b++) begin
            beat_vec[b] = '0;
            beat_vec[b][9] = (b < 9);
            beat_vec[b][0] = (b >= 12);
        end
        drive_run(2, 1, -1);
        wait_result("gaps");
    endtask

    task automatic test_ignored_inputs();
        for (int c = 0; c < 5; c++) begin
            valid_i = 1'b1;
            spike_i = '1;
            @(negedge clk_i);
            n_checks++;
            if (busy_o !== 1'b0 || done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_valid: busy/done = %b/%b, required 0/0", busy_o, done_o);
            end
        end
        valid_i = 1'b0;
        for (int b = 0; b < T_STEPS; b++) beat_vec[b] = '0;
        drive_run(0, 0, 8);
        wait_result("zero");
    endtask

    task automatic test_abort();
        bit saw_done;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int b = 0; b < 8; b++) begin
            valid_i = 1'b1;
            spike_i = '1;
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        spike_i = '0;
        rst_i   = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy: got %b, required 0", busy_o);
        end
        rst_i = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk_i);
            if (done_o !== 1'b0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL abort_no_done: done_o seen after aborted run, required none");
        end
        for (int b = 0; b < T_STEPS; b++) begin
            beat_vec[b] = '0;
            beat_vec[b][6] = (b < 12);
        end
        drive_run(0, 0, -1);
        wait_result("after_abort");
    endtask

    initial begin
        rst_i   = 1'b0;
        spike_i = '0;
        valid_i = 1'b0;
        start_i = 1'b0;
        test_reset();
        test_single_winner();
        test_tie();
        test_gaps();
        test_ignored_inputs();
        test_abort();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d results still queued, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_count_decoder.md
Name: spike_count_decoder

Overview:
Output-side decoder for the snn core: consumes the core's spike_o / next_stage stream, accumulates per-neuron spike counts over a fixed inference window of T_STEPS valid beats, then resolves the winning output neuron by a sequential argmax. It sits directly downstream of snn and presents a classification result plus a one-cycle done pulse to the system/bench.

Parameters:
N_OUT, 10, number of output neurons (width of spike bus)
T_STEPS, 16, valid beats per inference window
CNT_W, $clog2(T_STEPS+1), per-neuron counter width (derived; not overridden)
IDX_W, $clog2(N_OUT) (min 1), class index width (derived)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous, active-low reset
spike_i  in  N_OUT  spike vector from snn spike_o
valid_i  in  1  beat qualifier from snn next_stage
start_i  in  1  begin a new inference window (level sampled in IDLE/DONE only)
busy_o  out  1  high in ACCUM and SCAN
done_o  out  1  one-cycle pulse when result valid
class_o  out  IDX_W  winning neuron index
max_count_o  out  CNT_W  spike count of winner
tie_o  out  1  another neuron equals max_count_o

Behaviour:
- Reset (rst_i=0, async): state IDLE; all counters, step counter, scan index cleared; busy_o=0, done_o=0, class_o=0, max_count_o=0, tie_o=0. Reset mid-ACCUM or mid-SCAN aborts the run; no done_o.
- States: IDLE, ACCUM, SCAN, DONE.
- IDLE/DONE: start_i=1 -> clear all N_OUT counters and step counter, go ACCUM. Result outputs hold their last value until the next start is accepted, at which point class_o/max_count_o/tie_o clear to 0.
- ACCUM: on each edge with valid_i=1, counter[i] += spike_i[i] for every i, step += 1. Beats with valid_i=0 change nothing. When the edge samples beat number T_STEPS, go SCAN with scan index 0, best=0, best_cnt=0, tie=0.
- Counters cannot overflow: max value T_STEPS fits CNT_W.
- SCAN: one neuron per cycle, index 0..N_OUT-1. If counter[idx] > best_cnt: best=idx, best_cnt=counter[idx], tie=0. If equal and idx!=0: tie=1. Strict compare -> lowest index wins ties. After idx N_OUT-1 processed, go DONE.
- DONE: register class_o=best, max_count_o=best_cnt, tie_o=tie; done_o=1 for exactly this one cycle; next state IDLE unless start_i=1 (then ACCUM directly).
- Latency: done_o is high in the cycle beginning N_OUT+1 edges after the edge that samples the final valid beat (11 for defaults).
- All-zero window: class_o=0, max_count_o=0, tie_o=1 (when N_OUT>1).
- Ignored inputs: start_i while busy_o=1; valid_i/spike_i outside ACCUM.
- busy_o=1 exactly in ACCUM and SCAN; done_o never coincides with busy_o.

Test Plan:
1. Hold rst_i=0 for 5 cycles with random spike_i/valid_i/start_i -> all outputs 0, busy_o=0; release, idle with no done_o.
2. start_i, then 16 valid beats with spike_i=10'b0000001000 -> class_o=3, max_count_o=16, tie_o=0, done_o pulse exactly 11 cycles after last beat edge, single cycle wide.
3. 16 beats where neurons 2 and 7 each spike on 5 beats, neuron 4 on 3 -> class_o=2, max_count_o=5, tie_o=1.
4. 16 valid beats interleaved with 24 valid_i=0 cycles carrying spike_i=all-ones -> only valid beats counted; neuron 9 spiking on 9 beats wins with max_count_o=9.
5. start_i pulsed mid-ACCUM and valid beats driven in IDLE -> no restart, no extra counts; all-zero window -> class_o=0, max_count_o=0, tie_o=1.
6. Assert rst_i=0 after beat 8 of a run, release, start new run with neuron 6 on 12 beats -> no done_o from aborted run; new result class_o=6, max_count_o=12.
